hk_sys_bus_arbiter: RTL
=======================

// Module: hk_sys_bus_arbiter
// PURPOSE
//  Shares one housekeeping system-bus slave (ID/DNA/loopback register bank) between two
//  masters: m0 = PS AXI bridge, m1 = on-chip debug/scan master. Buffers one pending request
//  per master, grants round-robin, forwards one transaction at a time to the slave and
//  returns ack/err/rdata to the originating master. A hung slave is recovered by timeout.
// PARAMETERS
//  AW       32   address width, all buses
//  DW       32   data width, all buses
//  TIMEOUT  255  max cycles in WAIT before forced error response (1..2**16-1)
// PORTS
//  clk_i      in   1    clock
//  rst_i      in   1    asynchronous reset, active high
//  mN_addr    in   AW   master N (N=0,1) address
//  mN_wdata   in   DW   master N write data
//  mN_sel     in   4    master N byte select
//  mN_wen     in   1    master N write strobe, single-cycle pulse
//  mN_ren     in   1    master N read strobe, single-cycle pulse
//  mN_rdata   out  DW   master N read data, valid with mN_ack
//  mN_err     out  1    master N error, valid with mN_ack
//  mN_ack     out  1    master N acknowledge, single-cycle pulse
//  s_addr/s_wdata/s_sel/s_wen/s_ren  out  AW/DW/4/1/1  slave request
//  s_rdata    in   DW   slave read data
//  s_err      in   1    slave error
//  s_ack      in   1    slave acknowledge
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transaction): all outputs 0, both pending flags 0,
//    FSM=IDLE, last_grant=1 (m0 wins first tie), timeout counter 0. In-flight txn dropped.
//  - Capture: mN_wen|mN_ren sampled high while pend_N=0 -> latch addr/wdata/sel/wen/ren,
//    pend_N=1. Strobe while pend_N=1 is ignored (no ack ever issued for it).
//    wen and ren both high: latched as-is, forwarded unchanged.
//  - FSM IDLE: if any pend -> grant = only requester, or !last_grant when both; drive
//    s_* from granted buffer with s_wen/s_ren high for exactly one cycle; clear pend_grant;
//    last_grant<=grant; ->ISSUE. Granted master may queue a new request from this point.
//  - ISSUE (the strobe cycle) and WAIT: s_wen=s_ren=0 after ISSUE; s_addr/wdata/sel held.
//    s_ack|s_err sampled -> m_grant_ack=1 one cycle, m_grant_err=s_err,
//    m_grant_rdata=s_rdata; ->IDLE. ISSUE without ack ->WAIT, counter=0.
//  - WAIT: counter++ each cycle; counter==TIMEOUT-1 with no ack -> ack=1, err=1, rdata=0
//    to granted master; ->IDLE. Ack and timeout in same cycle: slave response wins.
//  - s_ack/s_err in IDLE are ignored (late ack after timeout discarded). Slaves on this bus
//    ack within TIMEOUT cycles; a late ack landing in a later txn's ISSUE/WAIT is out of scope.
//  - mN_rdata/mN_err hold last value between acks; other master's outputs untouched.
//  - Latency (idle arbiter, slave acks 1 cycle after strobe): strobe in cycle 0 ->
//    s strobe cycle 2 -> slave ack cycle 3 -> mN_ack cycle 4.
//  - Throughput: one txn per 3 cycles minimum; no back-to-back slave strobes.
// CONFIGURATION
//  HK_ARB_STATS_EN defined: adds outputs stat_grant0, stat_grant1, stat_tmo (16 bit each,
//    saturating at 16'hFFFF, reset 0): grants to m0, grants to m1, timeouts. Increment on
//    grant edge / timeout edge respectively.
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 m0 read 0x0 alone, slave acks 1 cycle later with 0x1 -> s_ren cycle 2, m0_ack cycle 4,
//    m0_rdata=0x1, m0_err=0, m1_ack never high.
//  2 m0 write and m1 read strobed same cycle after reset -> m0 served first, m1 strobe to
//    slave cycle after m0 ack; both ack exactly once, order m0 then m1.
//  3 Both masters strobe continuously every 4 cycles for 20 txns -> grants alternate
//    m0,m1,m0...; grant counts 10/10 (stats build); no lost or duplicated acks.
//  4 Slave never acks, TIMEOUT=8 -> m1_ack with m1_err=1, m1_rdata=0 after 8 WAIT cycles;
//    s_ack pulsed 2 cycles later in IDLE -> no master ack.
//  5 Reset asserted in WAIT with m1 pending -> all outputs 0 immediately; after release
//    no ack for either pre-reset request; new m1 read completes normally.
//  6 m0 second strobe while pend_0=1 -> ignored; exactly one m0_ack; strobe after grant
//    (cycle 3) -> queued and acked after current txn.

Source files
------------

// File: rtl/hk_sys_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// hk_sys_bus_arbiter_if
//   Bundles the request/response buses around the housekeeping bus arbiter:
//   two master-side request buses (m0 = PS AXI bridge, m1 = debug/scan master)
//   and the single slave-side bus to the ID/DNA/loopback register bank.
//
//   Handshake (same on every bus): a request is a single-cycle wen/ren pulse
//   with addr/wdata/sel valid in that same cycle. The response is a
//   single-cycle ack pulse; rdata and err are valid in the ack cycle. A
//   master issues a new request only after the previous one has been acked.
//   There is no ready/backpressure signal.
//
//   Modports:
//     slave  - the arbiter's view: takes master requests, returns master
//              responses, drives the slave request, takes the slave response.
//     master - the environment's view (masters plus the register bank), the
//              mirror image of 'slave'.
// -----------------------------------------------------------------------------
interface hk_sys_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // master 0
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [3:0]    m0_sel;
  logic          m0_wen;
  logic          m0_ren;
  logic [DW-1:0] m0_rdata;
  logic          m0_err;
  logic          m0_ack;
  // master 1
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [3:0]    m1_sel;
  logic          m1_wen;
  logic          m1_ren;
  logic [DW-1:0] m1_rdata;
  logic          m1_err;
  logic          m1_ack;
  // slave
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_sel;
  logic          s_wen;
  logic          s_ren;
  logic [DW-1:0] s_rdata;
  logic          s_err;
  logic          s_ack;

  modport slave (
    input  m0_addr, m0_wdata, m0_sel, m0_wen, m0_ren,
    output m0_rdata, m0_err, m0_ack,
    input  m1_addr, m1_wdata, m1_sel, m1_wen, m1_ren,
    output m1_rdata, m1_err, m1_ack,
    output s_addr, s_wdata, s_sel, s_wen, s_ren,
    input  s_rdata, s_err, s_ack
  );

  modport master (
    output m0_addr, m0_wdata, m0_sel, m0_wen, m0_ren,
    input  m0_rdata, m0_err, m0_ack,
    output m1_addr, m1_wdata, m1_sel, m1_wen, m1_ren,
    input  m1_rdata, m1_err, m1_ack,
    input  s_addr, s_wdata, s_sel, s_wen, s_ren,
    output s_rdata, s_err, s_ack
  );
endinterface

// File: rtl/hk_sys_bus_arbiter.sv
// -----------------------------------------------------------------------------
// hk_sys_bus_arbiter
//   Shares the housekeeping register-bank slave between two masters. Each
//   master has a one-deep request buffer; buffered requests are granted
//   round-robin and forwarded one at a time. The response goes back to the
//   master that was granted. If the slave does not answer within TIMEOUT
//   WAIT cycles, the arbiter returns an error (rdata 0) to that master.
//
// Ports
//   clk_i      clock
//   rst_i      asynchronous reset, active high
//   bus        hk_sys_bus_arbiter_if.slave (m0_*, m1_*, s_* buses)
//   dbg_state  current FSM state (IDLE=0, ISSUE=1, WAIT=2)
//   stat_grant0/stat_grant1/stat_tmo  16-bit saturating counters for grants
//              to m0, grants to m1, and timeouts. These ports exist only when
//              HK_ARB_STATS_EN is defined.
//
// Optional feature macro: HK_ARB_STATS_EN
//
// Timing with an idle arbiter, for a slave that acks one cycle after the
// strobe: master strobe in cycle 0, slave strobe in cycle 2, slave ack in
// cycle 3, master ack in cycle 4.
// -----------------------------------------------------------------------------
module hk_sys_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hk_sys_bus_arbiter_if.slave   bus,
  output logic [1:0]            dbg_state
`ifdef HK_ARB_STATS_EN
  ,
  output logic [15:0]           stat_grant0,
  output logic [15:0]           stat_grant1,
  output logic [15:0]           stat_tmo
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t        state;
  logic          grant;       // master that owns the current transaction
  logic          last_grant;  // reset to 1 so that m0 wins the first tie
  logic [15:0]   tmo_cnt;
  logic [1:0]    pend;
  logic [AW-1:0] buf_addr  [2];
  logic [DW-1:0] buf_wdata [2];
  logic [3:0]    buf_sel   [2];
  logic [1:0]    buf_wen;
  logic [1:0]    buf_ren;

  logic [1:0]    stb;
  logic          grant_nxt;
  logic          tmo_fire;
  logic          rsp_fire;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  assign dbg_state = state;
  assign stb = {bus.m1_wen | bus.m1_ren, bus.m0_wen | bus.m0_ren};

  // A slave response and a timeout in the same cycle resolve in favour of
  // the slave response, so tmo_fire requires that there is no ack or err.
  always_comb begin
    grant_nxt = (pend == 2'b11) ? ~last_grant : pend[1];
    tmo_fire  = (state == WAIT) && !(bus.s_ack | bus.s_err) &&
                (tmo_cnt == 16'(TIMEOUT - 1));
    rsp_fire  = (((state == ISSUE) || (state == WAIT)) && (bus.s_ack | bus.s_err))
                || tmo_fire;
    rsp_err   = bus.s_err | tmo_fire;
    rsp_rdata = tmo_fire ? '0 : bus.s_rdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      tmo_cnt      <= '0;
      pend         <= '0;
      buf_wen      <= '0;
      buf_ren      <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_addr[i]  <= '0;
        buf_wdata[i] <= '0;
        buf_sel[i]   <= '0;
      end
      bus.s_addr   <= '0;
      bus.s_wdata  <= '0;
      bus.s_sel    <= '0;
      bus.s_wen    <= 1'b0;
      bus.s_ren    <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m0_err   <= 1'b0;
      bus.m0_ack   <= 1'b0;
      bus.m1_rdata <= '0;
      bus.m1_err   <= 1'b0;
      bus.m1_ack   <= 1'b0;
`ifdef HK_ARB_STATS_EN
      stat_grant0  <= '0;
      stat_grant1  <= '0;
      stat_tmo     <= '0;
`endif
    end else begin
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;

      // Capture a strobe only into an empty buffer. A strobe that arrives
      // while the buffer is full is dropped and is never acked.
      if (stb[0] && !pend[0]) begin
        buf_addr[0]  <= bus.m0_addr;
        buf_wdata[0] <= bus.m0_wdata;
        buf_sel[0]   <= bus.m0_sel;
        buf_wen[0]   <= bus.m0_wen;
        buf_ren[0]   <= bus.m0_ren;
        pend[0]      <= 1'b1;
      end
      if (stb[1] && !pend[1]) begin
        buf_addr[1]  <= bus.m1_addr;
        buf_wdata[1] <= bus.m1_wdata;
        buf_sel[1]   <= bus.m1_sel;
        buf_wen[1]   <= bus.m1_wen;
        buf_ren[1]   <= bus.m1_ren;
        pend[1]      <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Late slave acks that arrive in IDLE are ignored here.
          if (|pend) begin
            grant           <= grant_nxt;
            last_grant      <= grant_nxt;
            pend[grant_nxt] <= 1'b0;   // the granted master may queue again
            bus.s_addr      <= buf_addr[grant_nxt];
            bus.s_wdata     <= buf_wdata[grant_nxt];
            bus.s_sel       <= buf_sel[grant_nxt];
            bus.s_wen       <= buf_wen[grant_nxt];
            bus.s_ren       <= buf_ren[grant_nxt];
            state           <= ISSUE;
`ifdef HK_ARB_STATS_EN
            if (!grant_nxt && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
            if ( grant_nxt && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
`endif
          end
        end
        ISSUE, WAIT: begin
          // The strobe lasts exactly one cycle. Address and data stay held.
          bus.s_wen <= 1'b0;
          bus.s_ren <= 1'b0;
          if (rsp_fire) begin
            if (grant) begin
              bus.m1_ack   <= 1'b1;
              bus.m1_err   <= rsp_err;
              bus.m1_rdata <= rsp_rdata;
            end else begin
              bus.m0_ack   <= 1'b1;
              bus.m0_err   <= rsp_err;
              bus.m0_rdata <= rsp_rdata;
            end
            state <= IDLE;
          end else if (state == ISSUE) begin
            tmo_cnt <= '0;
            state   <= WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`ifdef HK_ARB_STATS_EN
          if (tmo_fire && stat_tmo != 16'hFFFF) stat_tmo <= stat_tmo + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
